lsu_mem_ctrl: RTL and testbench

Load/store initiator that sits between the RV64I execute stage and the byte-addressed 64-bit data memory. It accepts one load or store request at a time and drives the memory's read and write ports. It sign- or zero-extends load data for LB/LH/LW/LD/LBU/LHU/LWU. Because the memory always writes 8 bytes, SB/SH/SW are done as read-modify-write.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_mem_ctrl_align.sv | 37 +++
 rtl/lsu_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: funct3 codes, FSM states and
// the request legality check applied at accept.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_RESP   = 3'd4
    } lsu_state_t;

    // Every access touches 8 bytes, so the last legal start is mem_bytes-8.
    function automatic logic lsu_legal(input logic        we,
                                       input logic [2:0]  f3,
                                       input logic [63:0] addr,
                                       input logic [63:0] mem_bytes);
        logic f3_ok;
        f3_ok = we ? ~f3[2] : (f3 != 3'b111);
        return f3_ok && (addr <= mem_bytes - 64'd8);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational data alignment: load sign/zero extension and the byte merge
// used by the read-modify-write path of partial stores.
module lsu_mem_ctrl_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_rdata,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load,
    output logic [63:0] o_merge
);

    always_comb begin
        o_load = i_rdata;
        case (i_funct3)
            F3_B:    o_load = {{56{i_rdata[7]}},  i_rdata[7:0]};
            F3_H:    o_load = {{48{i_rdata[15]}}, i_rdata[15:0]};
            F3_W:    o_load = {{32{i_rdata[31]}}, i_rdata[31:0]};
            F3_BU:   o_load = {56'd0, i_rdata[7:0]};
            F3_HU:   o_load = {48'd0, i_rdata[15:0]};
            F3_WU:   o_load = {32'd0, i_rdata[31:0]};
            default: o_load = i_rdata;
        endcase
    end

    // Byte 0 is the addressed byte, so partial stores replace the low bytes.
    always_comb begin
        o_merge = i_wdata;
        case (i_funct3)
            F3_B:    o_merge = {i_rdata[63:8],  i_wdata[7:0]};
            F3_H:    o_merge = {i_rdata[63:16], i_wdata[15:0]};
            F3_W:    o_merge = {i_rdata[63:32], i_wdata[31:0]};
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store initiator for a byte-addressed 64-bit memory;
// partial stores go through a read-modify-write sequence.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [63:0]       resp_rdata,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_rdaddress,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic [63:0]       mem_write_data,
    input  logic [63:0]       mem_read_data
);

    lsu_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [63:0]       r_wdata;
    logic              r_we;
    logic              r_err;
    logic [63:0]       r_merge;
    logic [63:0]       r_rdata;

    logic              w_accept;
    logic              w_legal;
    logic [63:0]       w_load_ext;
    logic [63:0]       w_merge;

    assign w_accept = req_valid & req_ready;
    assign w_legal  = lsu_legal(req_we, req_funct3, 64'(req_addr), 64'(MEM_BYTES));

    lsu_mem_ctrl_align u_align (
        .i_funct3 (r_funct3),
        .i_rdata  (mem_read_data),
        .i_wdata  (r_wdata),
        .o_load   (w_load_ext),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal)                w_next = S_RESP;
                    else if (!req_we)            w_next = S_LOAD;
                    else if (req_funct3 == F3_D) w_next = S_RMW_WR;
                    else                         w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Gating with rst keeps a reset cycle from handshaking or writing memory.
    always_comb begin
        req_ready  = (r_state == S_IDLE)   & ~rst;
        resp_valid = (r_state == S_RESP)   & ~rst;
        mem_rden   = ((r_state == S_LOAD) | (r_state == S_RMW_RD)) & ~rst;
        mem_wren   = (r_state == S_RMW_WR) & ~rst;
    end

    assign mem_rdaddress  = r_addr;
    assign mem_wraddress  = r_addr;
    assign mem_write_data = r_merge;
    assign resp_err       = r_err;
    assign resp_rdata     = r_rdata;

    // resp_rdata only changes on the edge entering RESP so it holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_merge  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata;
                        r_we     <= req_we;
                        r_err    <= ~w_legal;
                        r_merge  <= req_wdata;
                        if (!w_legal) r_rdata <= '0;
                    end
                end
                S_LOAD:   r_rdata <= w_load_ext;
                S_RMW_RD: r_merge <= w_merge;
                S_RMW_WR: if (r_we) r_rdata <= '0;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-array memory model, directed
// requests with hand-computed responses, and a monitor checking each response.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        mem_rden;
    logic        mem_wren;
    logic [31:0] mem_rdaddress;
    logic [31:0] mem_wraddress;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    lsu_mem_ctrl #(.MEM_BYTES(65536), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'd0;
    logic [63:0] pl_data = 64'd0;

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            mem_read_data[i*8 +: 8] = mem[16'(mem_rdaddress + 32'(i))];
    end

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 8; i++) mem[16'(pl_addr + 32'(i))] <= pl_data[i*8 +: 8];
        end else if (mem_wren) begin
            for (int i = 0; i < 8; i++) mem[16'(mem_wraddress + 32'(i))] <= mem_write_data[i*8 +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          err;
        logic [63:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] memword(input logic [31:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = mem[16'(a + 32'(i))];
        return w;
    endfunction

    // Monitor: samples 1 time unit after each falling edge.
    bit          in_txn = 0;
    int          acc_cyc, n_rd, n_wr, last_resp = -100, last_gap = 0;
    bit          bad_addr, rdy_busy;
    logic [31:0] cur_addr;

    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            in_txn = 0;
        end else begin
            if (in_txn) begin
                if (mem_rden) begin
                    n_rd++;
                    if (mem_rdaddress !== cur_addr) bad_addr = 1;
                end
                if (mem_wren) begin
                    n_wr++;
                    if (mem_wraddress !== cur_addr) bad_addr = 1;
                end
                if (req_ready) rdy_busy = 1;
            end
            if (resp_valid) begin
                if (!in_txn || sb.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_err",   64'(resp_err), 64'(e.err));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency",    64'(cyc - acc_cyc), 64'(e.lat));
                    chk("rden_cycles", 64'(n_rd), 64'(e.nrd));
                    chk("wren_cycles", 64'(n_wr), 64'(e.nwr));
                    chk("mem_addr",   64'(bad_addr), 64'd0);
                    chk("ready_busy", 64'(rdy_busy), 64'd0);
                end
                last_resp = cyc;
                in_txn = 0;
            end
            if (req_valid && req_ready) begin
                in_txn   = 1;
                acc_cyc  = cyc;
                last_gap = cyc - last_resp;
                n_rd = 0; n_wr = 0; bad_addr = 0; rdy_busy = 0;
                cur_addr = req_addr;
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [63:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd, input bit e_err, input logic [63:0] e_rd,
                         input int lat, input int nrd, input int nwr, input bit keep);
        exp_t e;
        int   n = 0;
        e.err = e_err; e.rdata = e_rd; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
        sb.push_back(e);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_timeout", 64'd1, 64'd0);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while ((sb.size() != 0 || in_txn) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("resp_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready",  64'(req_ready),  64'd0);
        chk("rst_valid",  64'(resp_valid), 64'd0);
        chk("rst_wren",   64'(mem_wren),   64'd0);
        chk("rst_rden",   64'(mem_rden),   64'd0);
        chk("rst_rdata",  resp_rdata,      64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        @(negedge clk);

        preload(32'h100,  64'h0000_0000_0000_0080);
        preload(32'h300,  64'hAAAA_AAAA_AAAA_AAAA);
        preload(32'hFFF8, 64'h0000_0000_8000_0001);

        // Loads with extension
        issue(0, 3'b000, 32'h100, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1, 0, 0); wait_done;
        issue(0, 3'b100, 32'h100, 0, 0, 64'h0000_0000_0000_0080, 2, 1, 0, 0); wait_done;

        // SD then LD
        issue(1, 3'b011, 32'h200, 64'h1122_3344_5566_7788, 0, 64'd0, 2, 0, 1, 0); wait_done;
        chk("mem_sd", memword(32'h200), 64'h1122_3344_5566_7788);
        issue(0, 3'b011, 32'h200, 0, 0, 64'h1122_3344_5566_7788, 2, 1, 0, 0); wait_done;

        // SH read-modify-write; upper wdata bytes must be ignored
        issue(1, 3'b001, 32'h300, 64'hFFFF_FFFF_FFFF_1234, 0, 64'd0, 3, 1, 1, 0); wait_done;
        chk("mem_sh", memword(32'h300), 64'hAAAA_AAAA_AAAA_1234);
        issue(0, 3'b110, 32'h300, 0, 0, 64'h0000_0000_AAAA_1234, 2, 1, 0, 0); wait_done;
        issue(0, 3'b010, 32'h300, 0, 0, 64'hFFFF_FFFF_AAAA_1234, 2, 1, 0, 0); wait_done;
        issue(0, 3'b001, 32'h302, 0, 0, 64'hFFFF_FFFF_FFFF_AAAA, 2, 1, 0, 0); wait_done;
        issue(0, 3'b101, 32'h302, 0, 0, 64'h0000_0000_0000_AAAA, 2, 1, 0, 0); wait_done;

        // SW then SB at an unaligned address
        issue(1, 3'b010, 32'h300, 64'h0123_4567_CAFE_BABE, 0, 64'd0, 3, 1, 1, 0); wait_done;
        chk("mem_sw", memword(32'h300), 64'hAAAA_AAAA_CAFE_BABE);
        issue(1, 3'b000, 32'h301, 64'hFFFF_FFFF_FFFF_FF55, 0, 64'd0, 3, 1, 1, 0); wait_done;
        chk("mem_sb", memword(32'h300), 64'hAAAA_AAAA_CAFE_55BE);

        // Range boundary and illegal funct3
        issue(0, 3'b010, 32'hFFF8, 0, 0, 64'hFFFF_FFFF_8000_0001, 2, 1, 0, 0); wait_done;
        issue(0, 3'b010, 32'hFFF9, 0, 1, 64'd0, 1, 0, 0, 0); wait_done;
        issue(0, 3'b000, 32'h100, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1, 0, 0); wait_done;
        issue(0, 3'b111, 32'h100, 0, 1, 64'd0, 1, 0, 0, 0); wait_done;
        issue(1, 3'b100, 32'h300, 64'h77, 1, 64'd0, 1, 0, 0, 0); wait_done;
        chk("mem_bad_store", memword(32'h300), 64'hAAAA_AAAA_CAFE_55BE);

        // Reset while an SB sits in RMW_WR: no write, no response
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h300;
        req_wdata = 64'h99; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rmw_wren", 64'(mem_wren), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rmw_ready", 64'(req_ready), 64'd1);
        repeat (4) @(negedge clk);
        chk("rst_rmw_mem", memword(32'h300), 64'hAAAA_AAAA_CAFE_55BE);

        // Back-to-back with req_valid held high
        issue(0, 3'b011, 32'h200, 0, 0, 64'h1122_3344_5566_7788, 2, 1, 0, 1);
        issue(0, 3'b100, 32'h100, 0, 0, 64'h0000_0000_0000_0080, 2, 1, 0, 0);
        wait_done;
        chk("b2b_gap", 64'(last_gap), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=<200000", $time);
        $fatal(1);
    end

endmodule
